// File: rtl/vm_change_pkg.sv
// Shared types and constants for the change dispenser: FSM states,
// coin denominations and their unit values.
package vm_change_pkg;

  localparam int unsigned AMT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    ISSUE,
    DONE,
    FAULT
  } state_e;

  localparam logic DEN_1 = 1'b0;
  localparam logic DEN_2 = 1'b1;

  localparam logic [AMT_W-1:0] COIN_VAL_1 = 4'd1;
  localparam logic [AMT_W-1:0] COIN_VAL_2 = 4'd2;

  function automatic logic [AMT_W-1:0] coin_value(input logic den);
    return (den == DEN_2) ? COIN_VAL_2 : COIN_VAL_1;
  endfunction

endpackage

// File: rtl/change_hopper_ctr.sv
// Coin level of one hopper: saturating add on refill, floor-at-zero
// decrement on each ejected coin.
module change_hopper_ctr
  import vm_change_pkg::*;
#(
  parameter int unsigned CAP = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [AMT_W-1:0] inc_amt,
  input  logic             dec_en,
  output logic [AMT_W-1:0] level
);

  logic [AMT_W-1:0] level_d, level_q;
  logic [AMT_W:0]   sum;

  always_comb begin
    sum     = {1'b0, level_q} + {1'b0, inc_amt};
    level_d = level_q;
    if (inc_en) begin
      level_d = (sum > (AMT_W+1)'(CAP)) ? AMT_W'(CAP) : sum[AMT_W-1:0];
    end else if (dec_en && (level_q != '0)) begin
      level_d = level_q - AMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end

  assign level = level_q;

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedily ejects 2-unit then 1-unit coins from
// two hoppers until the accepted amount is paid, with ack timeout.
module change_dispenser
  import vm_change_pkg::*;
#(
  parameter int unsigned HOPPER_CAP  = 15,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_req,
  input  logic [AMT_W-1:0] change_amount,
  output logic             ready,
  input  logic             refill,
  input  logic             refill_den,
  input  logic [AMT_W-1:0] refill_count,
  output logic             dispense_valid,
  output logic             dispense_den,
  input  logic             dispense_ack,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] level1,
  output logic [AMT_W-1:0] level2
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_e           state_d, state_q;
  logic [AMT_W-1:0] remaining_d, remaining_q;
  logic             den_d, den_q;
  logic [TMO_W-1:0] tmo_d, tmo_q;
  logic             inc1, inc2, dec1, dec2;

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    den_d          = den_q;
    tmo_d          = tmo_q;
    ready          = 1'b0;
    dispense_valid = 1'b0;
    done           = 1'b0;
    fault          = 1'b0;
    inc1           = 1'b0;
    inc2           = 1'b0;
    dec1           = 1'b0;
    dec2           = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (refill) begin
          inc1 = (refill_den == DEN_1);
          inc2 = (refill_den == DEN_2);
        end
        if (change_req) begin
          remaining_d = change_amount;
          state_d     = SEL;
        end
      end
      SEL: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if ((remaining_q >= COIN_VAL_2) && (level2 != '0)) begin
          den_d   = DEN_2;
          tmo_d   = '0;
          state_d = ISSUE;
        end else if (level1 != '0) begin
          den_d   = DEN_1;
          tmo_d   = '0;
          state_d = ISSUE;
        end else begin
          state_d = FAULT;
        end
      end
      ISSUE: begin
        dispense_valid = 1'b1;
        if (dispense_ack) begin
          dec1        = (den_q == DEN_1);
          dec2        = (den_q == DEN_2);
          remaining_d = remaining_q - coin_value(den_q);
          state_d     = SEL;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      FAULT: begin
        fault   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      den_q       <= DEN_1;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      den_q       <= den_d;
      tmo_q       <= tmo_d;
    end
  end

  change_hopper_ctr #(.CAP(HOPPER_CAP)) u_hopper1 (
    .clk    (clk),
    .reset  (reset),
    .inc_en (inc1),
    .inc_amt(refill_count),
    .dec_en (dec1),
    .level  (level1)
  );

  change_hopper_ctr #(.CAP(HOPPER_CAP)) u_hopper2 (
    .clk    (clk),
    .reset  (reset),
    .inc_en (inc2),
    .inc_amt(refill_count),
    .dec_en (dec2),
    .level  (level2)
  );

  assign dispense_den = den_q;
  assign remaining    = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: transaction-level hopper/amount model,
// per-cycle idle compare, and literal expectations for the key scenarios.
module tb_change_dispenser;

  localparam int unsigned HOPPER_CAP  = 15;
  localparam int unsigned ACK_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       change_req = 1'b0;
  logic [3:0] change_amount = '0;
  logic       ready;
  logic       refill = 1'b0;
  logic       refill_den = 1'b0;
  logic [3:0] refill_count = '0;
  logic       dispense_valid;
  logic       dispense_den;
  logic       dispense_ack = 1'b0;
  logic       done;
  logic       fault;
  logic [3:0] remaining;
  logic [3:0] level1;
  logic [3:0] level2;

  change_dispenser #(.HOPPER_CAP(HOPPER_CAP), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .change_req    (change_req),
    .change_amount (change_amount),
    .ready         (ready),
    .refill        (refill),
    .refill_den    (refill_den),
    .refill_count  (refill_count),
    .dispense_valid(dispense_valid),
    .dispense_den  (dispense_den),
    .dispense_ack  (dispense_ack),
    .done          (done),
    .fault         (fault),
    .remaining     (remaining),
    .level1        (level1),
    .level2        (level2)
  );

  always #5 clk = ~clk;

  int  pass_cnt = 0;
  int  chk_cnt  = 0;
  int  exp_l1 = 0, exp_l2 = 0, exp_rem = 0;
  bit  chk_idle = 1'b0;
  int  got_coins[$];
  bit  got_done, got_fault;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_refill(input bit den, input int cnt);
    if (den) exp_l2 = (exp_l2 + cnt > HOPPER_CAP) ? HOPPER_CAP : exp_l2 + cnt;
    else     exp_l1 = (exp_l1 + cnt > HOPPER_CAP) ? HOPPER_CAP : exp_l1 + cnt;
  endfunction

  // Whenever the bench expects the DUT to sit in IDLE, every output must match the model.
  always @(posedge clk) begin
    #1;
    if (chk_idle && !reset) begin
      check("idle_ready", ready, 1);
      check("idle_valid", dispense_valid, 0);
      check("idle_done", done, 0);
      check("idle_fault", fault, 0);
      check("idle_level1", level1, exp_l1);
      check("idle_level2", level2, exp_l2);
      check("idle_remaining", remaining, exp_rem);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_l1 = 0; exp_l2 = 0; exp_rem = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", dispense_valid, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_remaining", remaining, 0);
    check("rst_level1", level1, 0);
    check("rst_level2", level2, 0);
    reset = 1'b0;
    chk_idle = 1'b1;
  endtask

  task automatic do_refill(input bit den, input int cnt);
    @(negedge clk);
    refill = 1'b1; refill_den = den; refill_count = 4'(cnt);
    model_refill(den, cnt);
    @(negedge clk);
    refill = 1'b0;
  endtask

  task automatic pay(input int amt, input bit ack_on, input bit rf_en, input bit rf_den_i,
                     input int rf_cnt, input bit rf_in_issue);
    int exp_coins[$];
    bit exp_flt, fin, prev_ack;
    int l1, l2, r, ci, vcnt, first_t, paid;
    @(negedge clk);
    change_req = 1'b1; change_amount = 4'(amt); chk_idle = 1'b0;
    if (rf_en) begin
      refill = 1'b1; refill_den = rf_den_i; refill_count = 4'(rf_cnt);
      model_refill(rf_den_i, rf_cnt);
    end
    l1 = exp_l1; l2 = exp_l2; r = amt; exp_flt = 1'b0;
    while (r > 0 && !exp_flt) begin
      if (r >= 2 && l2 > 0) begin exp_coins.push_back(2); l2--; r -= 2; end
      else if (l1 > 0)      begin exp_coins.push_back(1); l1--; r -= 1; end
      else exp_flt = 1'b1;
    end
    got_coins.delete(); got_done = 1'b0; got_fault = 1'b0;
    ci = 0; vcnt = 0; fin = 1'b0; first_t = 0; paid = 0; prev_ack = 1'b0;
    for (int t = 1; t <= 64 && !fin; t++) begin
      @(negedge clk);
      change_req = 1'b0; refill = 1'b0; dispense_ack = 1'b0;
      if (prev_ack) check("valid_low_after_ack", dispense_valid, 0);
      prev_ack = 1'b0;
      if (done || fault) begin
        fin = 1'b1; got_done = done; got_fault = fault;
        if (amt == 0) begin
          check("zero_done_latency", t, 2);
          check("zero_no_valid", vcnt, 0);
        end
        if (ack_on) begin
          check("end_done", done, exp_flt ? 0 : 1);
          check("end_fault", fault, exp_flt ? 1 : 0);
          check("coin_count", got_coins.size(), exp_coins.size());
        end else begin
          check("timeout_fault", fault, 1);
          check("timeout_valid_cycles", vcnt, ACK_TIMEOUT);
        end
        exp_rem = amt - paid;
        chk_idle = 1'b1;
      end else if (dispense_valid) begin
        vcnt++;
        if (first_t == 0) begin
          first_t = t;
          check("first_valid_latency", t, 2);
        end
        if (ack_on) begin
          got_coins.push_back(dispense_den ? 2 : 1);
          check("coin_den", dispense_den ? 2 : 1, (ci < exp_coins.size()) ? exp_coins[ci] : 0);
          if (dispense_den) exp_l2--; else exp_l1--;
          paid += dispense_den ? 2 : 1;
          dispense_ack = 1'b1; prev_ack = 1'b1; ci++;
        end else if (rf_in_issue && vcnt == 3) begin
          refill = 1'b1; refill_den = 1'b1; refill_count = 4'd5;
        end
      end
    end
    if (!fin) begin
      check("payout_terminated", 0, 1);
      chk_idle = 1'b0;
    end
  endtask

  initial begin
    do_reset();

    // Levels 3/3, amount 5: coins 2,2,1.
    do_refill(1'b0, 3);
    do_refill(1'b1, 3);
    pay(5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("r036_coins", got_coins.size(), 3);
    if (got_coins.size() == 3) begin
      check("r036_coin0", got_coins[0], 2);
      check("r036_coin1", got_coins[1], 2);
      check("r036_coin2", got_coins[2], 1);
    end
    check("r036_done", got_done, 1);
    check("r036_level1", level1, 2);
    check("r036_level2", level2, 1);
    check("r036_remaining", remaining, 0);

    pay(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("r037_done", got_done, 1);

    // Drain the 2-unit hopper, then 1-unit hopper short by one unit.
    pay(2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    do_refill(1'b0, 1);
    pay(4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("r038_fault", got_fault, 1);
    check("r038_coins", got_coins.size(), 3);
    check("r038_remaining", remaining, 1);
    check("r038_level1", level1, 0);

    @(negedge clk) dispense_ack = 1'b1;
    repeat (3) @(negedge clk);
    dispense_ack = 1'b0;

    do_refill(1'b0, 12);
    do_refill(1'b0, 10);
    @(negedge clk);
    check("r040_saturate", level1, 15);
    do_refill(1'b1, 5);

    pay(3, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("r039_fault", got_fault, 1);
    check("r039_level1", level1, 15);
    check("r039_level2", level2, 5);
    check("r039_remaining", remaining, 3);

    // Refill and request together: only the refilled 2-unit coin is available.
    do_reset();
    pay(2, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    @(negedge clk);
    check("r030_done", got_done, 1);
    check("r030_level2", level2, 0);

    do_refill(1'b0, 4);
    @(negedge clk);
    change_req = 1'b1; change_amount = 4'd3; chk_idle = 1'b0;
    @(negedge clk);
    change_req = 1'b0;
    for (int t = 0; t < 8 && !dispense_valid; t++) @(negedge clk);
    check("r041_in_issue", dispense_valid, 1);
    reset = 1'b1;
    exp_l1 = 0; exp_l2 = 0; exp_rem = 0;
    @(negedge clk);
    check("r041_valid", dispense_valid, 0);
    check("r041_ready", ready, 1);
    check("r041_level1", level1, 0);
    check("r041_level2", level2, 0);
    reset = 1'b0;
    chk_idle = 1'b1;
    repeat (3) @(negedge clk);

    chk_idle = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
